// File: rtl/trace_byte_streamer.sv
// Buffers 36-bit trace words in a FIFO and serializes each into a 5-byte valid/ready stream.
// Optional TRACE_TRAP_MARK_EN: a rising i_trap edge enqueues a tagged entry that emits F0,00,00,00,00.
module trace_byte_streamer #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_trace_valid,
   input  logic [35:0]           i_trace_data,
   input  logic                  i_trap,
   input  logic                  i_clr,
   output logic                  o_byte_valid,
   output logic [7:0]            o_byte_data,
   input  logic                  i_byte_ready,
   output logic                  o_empty,
   output logic                  o_full,
   output logic [DEPTH_LOG2:0]   o_level,
   output logic                  o_overflow,
   output logic [CNT_W-1:0]      o_drop_cnt
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
`ifdef TRACE_TRAP_MARK_EN
   localparam int unsigned ENTRY_W = 37;
`else
   localparam int unsigned ENTRY_W = 36;
`endif

   typedef enum logic {S_IDLE, S_SEND} state_e;

   logic [ENTRY_W-1:0]    mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  empty_q, empty_d, full_q, full_d;
   state_e                state_q, state_d;
   logic [2:0]            idx_q, idx_d;
   logic [31:0]           shreg_q, shreg_d;
   logic                  byte_valid_q, byte_valid_d;
   logic [7:0]            byte_data_q, byte_data_d;
   logic                  overflow_q, overflow_d;
   logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;

   logic                  push_req_c, push_c, pop_c, drop_c, xfer_c;
   logic [ENTRY_W-1:0]    push_data_c, head_c;
   logic [7:0]            head_byte0_c;
   logic [31:0]           head_rest_c;

   assign head_c = mem_q[rd_ptr_q];

`ifdef TRACE_TRAP_MARK_EN
   logic trap_prev_q, trap_pend_q, trap_pend_d, trap_want_c;

   // A trace word wins the write slot; the trap entry waits one edge in trap_pend_q.
   always_comb begin
      trap_want_c  = trap_pend_q | (i_trap & ~trap_prev_q);
      push_req_c   = i_trace_valid | trap_want_c;
      push_data_c  = i_trace_valid ? {1'b0, i_trace_data} : {1'b1, 36'd0};
      trap_pend_d  = trap_want_c & i_trace_valid;
      head_byte0_c = head_c[36] ? 8'hF0 : {4'hA, head_c[35:32]};
      head_rest_c  = head_c[36] ? 32'd0 : head_c[31:0];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         trap_prev_q <= 1'b0;
         trap_pend_q <= 1'b0;
      end else begin
         trap_prev_q <= i_trap;
         trap_pend_q <= trap_pend_d;
      end
   end
`else
   logic unused_trap;
   assign unused_trap  = i_trap;
   assign push_req_c   = i_trace_valid;
   assign push_data_c  = i_trace_data;
   assign head_byte0_c = {4'hA, head_c[35:32]};
   assign head_rest_c  = head_c[31:0];
`endif

   // Serializer next-state and byte register; pops are issued from here.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      shreg_d      = shreg_q;
      byte_valid_d = byte_valid_q;
      byte_data_d  = byte_data_q;
      pop_c        = 1'b0;
      xfer_c       = byte_valid_q & i_byte_ready;
      case (state_q)
         S_IDLE: begin
            byte_valid_d = 1'b0;
            if (!empty_q) begin
               pop_c        = 1'b1;
               byte_valid_d = 1'b1;
               byte_data_d  = head_byte0_c;
               shreg_d      = head_rest_c;
               idx_d        = 3'd0;
               state_d      = S_SEND;
            end
         end
         S_SEND: begin
            if (xfer_c) begin
               if (idx_q != 3'd4) begin
                  idx_d       = idx_q + 3'd1;
                  byte_data_d = shreg_q[31:24];
                  shreg_d     = {shreg_q[23:0], 8'h00};
               end else if (!empty_q) begin
                  pop_c       = 1'b1;
                  byte_data_d = head_byte0_c;
                  shreg_d     = head_rest_c;
                  idx_d       = 3'd0;
               end else begin
                  byte_valid_d = 1'b0;
                  state_d      = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO bookkeeping and drop accounting; a full FIFO still accepts when a pop frees a slot.
   always_comb begin
      push_c     = push_req_c & (~full_q | pop_c);
      drop_c     = push_req_c & ~push_c;
      wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(push_c);
      rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(pop_c);
      level_d    = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
      empty_d    = (level_d == '0);
      full_d     = (level_d == LVL_W'(DEPTH));
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (i_clr) begin
         overflow_d = drop_c;
         drop_cnt_d = CNT_W'(drop_c);
      end else if (drop_c) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (push_c) mem_q[wr_ptr_q] <= push_data_c;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         empty_q      <= 1'b1;
         full_q       <= 1'b0;
         state_q      <= S_IDLE;
         idx_q        <= 3'd0;
         shreg_q      <= '0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= 8'h00;
         overflow_q   <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         empty_q      <= empty_d;
         full_q       <= full_d;
         state_q      <= state_d;
         idx_q        <= idx_d;
         shreg_q      <= shreg_d;
         byte_valid_q <= byte_valid_d;
         byte_data_q  <= byte_data_d;
         overflow_q   <= overflow_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign o_byte_valid = byte_valid_q;
   assign o_byte_data  = byte_data_q;
   assign o_empty      = empty_q;
   assign o_full       = full_q;
   assign o_level      = level_q;
   assign o_overflow   = overflow_q;
   assign o_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_trace_byte_streamer.sv
// Directed bench for trace_byte_streamer: byte scoreboard fed at push time, drained by a monitor.
// A second instance with CNT_W=4 shares all inputs to observe counter saturation.
module tb_trace_byte_streamer;

   logic        clk, rst_n;
   logic        trace_valid, trap, clr, byte_ready;
   logic [35:0] trace_data;

   logic        byte_valid, empty, full, overflow;
   logic [7:0]  byte_data;
   logic [4:0]  level;
   logic [15:0] drop_cnt;

   logic        s_byte_valid, s_empty, s_full, s_overflow;
   logic [7:0]  s_byte_data;
   logic [4:0]  s_level;
   logic [3:0]  s_drop_cnt;

   int tests = 0;
   int fails = 0;
   int xfer_cnt = 0;
   logic [7:0] exp_q [$];
   logic       stall_prev = 1'b0;
   logic [7:0] stall_data = 8'h00;

   trace_byte_streamer #(.DEPTH_LOG2(4), .CNT_W(16)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_trace_valid(trace_valid), .i_trace_data(trace_data),
      .i_trap(trap), .i_clr(clr), .o_byte_valid(byte_valid), .o_byte_data(byte_data),
      .i_byte_ready(byte_ready), .o_empty(empty), .o_full(full), .o_level(level),
      .o_overflow(overflow), .o_drop_cnt(drop_cnt));

   trace_byte_streamer #(.DEPTH_LOG2(4), .CNT_W(4)) u_sat (
      .i_clk(clk), .i_rst_n(rst_n), .i_trace_valid(trace_valid), .i_trace_data(trace_data),
      .i_trap(trap), .i_clr(clr), .o_byte_valid(s_byte_valid), .o_byte_data(s_byte_data),
      .i_byte_ready(byte_ready), .o_empty(s_empty), .o_full(s_full), .o_level(s_level),
      .o_overflow(s_overflow), .o_drop_cnt(s_drop_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [35:0] w);
      exp_q.push_back({4'hA, w[35:32]});
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   task automatic drain(input string tag, input int max_cycles, input bit toggle);
      int n = 0;
      while ((exp_q.size() != 0 || byte_valid) && n < max_cycles) begin
         if (toggle) byte_ready = ~byte_ready;
         tick();
         n++;
      end
      byte_ready = 1'b1;
      check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   // Byte monitor: checks each accepted byte against the scoreboard and hold-while-stalled.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", 64'(byte_valid), 64'd1);
            check("hold_data", 64'(byte_data), 64'(stall_data));
         end
         if (byte_valid && byte_ready) begin
            check("byte_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("byte_data", 64'(byte_data), 64'(exp_q.pop_front()));
            xfer_cnt <= xfer_cnt + 1;
         end
         stall_prev <= byte_valid & ~byte_ready;
         stall_data <= byte_data;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1);
   end

   initial begin
      logic [35:0] w;
      int          max_lvl, gaps, base, n;
      bit          started;
      rst_n = 1'b1; trace_valid = 1'b0; trace_data = '0; trap = 1'b0; clr = 1'b0; byte_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full", 64'(full), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      check("rst_valid", 64'(byte_valid), 64'd0);
      check("rst_data", 64'(byte_data), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Single word: latency and byte order.
      trace_valid = 1'b1; trace_data = 36'h3_1234_5678; push_frame(trace_data);
      tick();
      trace_valid = 1'b0;
      check("t1_level", 64'(level), 64'd1);
      check("t1_nvalid", 64'(byte_valid), 64'd0);
      tick();
      check("t1_valid", 64'(byte_valid), 64'd1);
      check("t1_byte0", 64'(byte_data), 64'hA3);
      drain("t1", 20, 1'b0);
      check("t1_empty", 64'(empty), 64'd1);

      // Three back-to-back words: no bubble, level peaks at 2.
      max_lvl = 0; gaps = 0; started = 1'b0;
      for (int i = 0; i < 3; i++) begin
         w = {4'($urandom), 32'($urandom)};
         trace_valid = 1'b1; trace_data = w; push_frame(w);
         tick();
         if (int'(level) > max_lvl) max_lvl = int'(level);
      end
      trace_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         if (byte_valid) started = 1'b1;
         else if (started) gaps++;
         if (int'(level) > max_lvl) max_lvl = int'(level);
         tick();
         n++;
      end
      check("t2_gaps", 64'(gaps), 64'd0);
      check("t2_maxlvl", 64'(max_lvl), 64'd2);
      drain("t2", 10, 1'b0);

      // Fill with ready low: one word sits in the serializer, 16 in the FIFO, 4 dropped.
      byte_ready = 1'b0;
      for (int i = 0; i < 21; i++) begin
         w = {4'($urandom), 32'($urandom)};
         trace_valid = 1'b1; trace_data = w;
         if (i < 17) push_frame(w);
         tick();
      end
      trace_valid = 1'b0;
      check("t3_full", 64'(full), 64'd1);
      check("t3_level", 64'(level), 64'd16);
      check("t3_drop", 64'(drop_cnt), 64'd4);
      check("t3_ovf", 64'(overflow), 64'd1);
      check("t3_sdrop", 64'(s_drop_cnt), 64'd4);
      for (int i = 0; i < 16; i++) begin
         trace_valid = 1'b1; trace_data = 36'(i);
         tick();
      end
      check("t3_drop20", 64'(drop_cnt), 64'd20);
      check("t3_sat", 64'(s_drop_cnt), 64'd15);
      clr = 1'b1;
      tick();
      trace_valid = 1'b0;
      check("t3_clrdrop", 64'(drop_cnt), 64'd1);
      check("t3_clrovf", 64'(overflow), 64'd1);
      check("t3_sclrdrop", 64'(s_drop_cnt), 64'd1);
      tick();
      clr = 1'b0;
      check("t3_clr0", 64'(drop_cnt), 64'd0);
      check("t3_clrovf0", 64'(overflow), 64'd0);
      byte_ready = 1'b1;
      drain("t3", 120, 1'b0);
      check("t3_empty", 64'(empty), 64'd1);

      // Ready toggling every cycle.
      for (int i = 0; i < 4; i++) begin
         w = {4'($urandom), 32'($urandom)};
         trace_valid = 1'b1; trace_data = w; push_frame(w);
         byte_ready = ~byte_ready;
         tick();
      end
      trace_valid = 1'b0;
      drain("t4", 80, 1'b1);

      // Reset after byte2 of a frame; the rest of that frame is abandoned.
      w = 36'h5_AABB_CCDD;
      trace_valid = 1'b1; trace_data = w; push_frame(w);
      base = xfer_cnt;
      tick();
      trace_valid = 1'b0;
      n = 0;
      while (xfer_cnt < base + 3 && n < 20) begin
         tick();
         n++;
      end
      check("t5_reached", 64'(xfer_cnt - base), 64'd3);
      rst_n = 1'b0;
      #1;
      check("t5_rvalid", 64'(byte_valid), 64'd0);
      check("t5_rempty", 64'(empty), 64'd1);
      exp_q.delete();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         w = {4'($urandom), 32'($urandom)};
         trace_valid = 1'b1; trace_data = w; push_frame(w);
         tick();
      end
      trace_valid = 1'b0;
      check("t5_hdr", 64'(byte_data[7:4]), 64'hA);
      drain("t5", 30, 1'b0);

`ifdef TRACE_TRAP_MARK_EN
      // Trace word and trap edge together: trace frame first, then the trap frame.
      w = 36'h7_0102_0304;
      trace_valid = 1'b1; trace_data = w; trap = 1'b1; push_frame(w);
      exp_q.push_back(8'hF0);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
      tick();
      trace_valid = 1'b0;
      tick(); tick();
      trap = 1'b0;
      drain("t6", 30, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
